// File: rtl/scsi_port_sm.sv
// SCSI (WD33C93A) 8-bit port controller for the SDMAC replacement.
// Runs CPU register cycles and DMA byte transfers between the SCSI chip and
// the longword FIFO, and hands FIFO count updates to the CPU-side master.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  S_IDLE      | no cycle; arbitration CPU > DMA read > DMA write
//  S_CRD       | CPU read, chip select + read strobe, ACC_CYCLES long
//  S_CRD_LAT   | CPU read, strobe held, LS2CPU low to latch the data
//  S_CWR       | CPU write, chip select + write strobe, ACC_CYCLES long
//  S_CWR_HOLD  | CPU write, strobe released, data held one cycle
//  S_CACK      | CPU acknowledge until the address strobe drops
//  S_DRD       | DMA SCSI->FIFO, DACK + read strobe, ACC_CYCLES long
//  S_DRD_LAT   | DMA SCSI->FIFO, LBYTE_ low latches the byte
//  S_DWR       | DMA FIFO->SCSI, DACK + write strobe, ACC_CYCLES long
//  S_DWR_HOLD  | DMA FIFO->SCSI, strobe released, data held one cycle
//  S_END       | byte pointer advance; longword pointer advance on byte 3
//  S_HSI       | RIFIFO_o until INCFIFO
//  S_HSO       | RDFIFO_o until DECFIFO
module scsi_port_sm #(
    parameter int ACC_CYCLES = 3
) (
    input  logic BCLK,
    input  logic RESET_,
    input  logic CPUREQ,
    input  logic RW,
    input  logic nAS_,
    input  logic DMADIR,
    input  logic DREQ_,
    input  logic FIFOFULL,
    input  logic FIFOEMPTY,
    input  logic BOEQ3,
    input  logic INCFIFO,
    input  logic DECFIFO,
    output logic SCSI_CS_o,
    output logic DACK_o,
    output logic RE_o,
    output logic WE_o,
    output logic S2CPU_o,
    output logic CPU2S_o,
    output logic S2F_o,
    output logic F2S_o,
    output logic LS2CPU,
    output logic LBYTE_,
    output logic INCBO_o,
    output logic INCNI_o,
    output logic INCNO_o,
    output logic RIFIFO_o,
    output logic RDFIFO_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_CRD, S_CRD_LAT, S_CWR, S_CWR_HOLD, S_CACK,
        S_DRD, S_DRD_LAT, S_DWR, S_DWR_HOLD, S_END, S_HSI, S_HSO
    } state_t;

    // Down-counter reload: terminal count 0 ends the strobe phase.
    localparam logic [2:0] CNT_LOAD = 3'(ACC_CYCLES - 1);

    // Output vector bit positions.
    localparam int O_CS    = 14;
    localparam int O_DACK  = 13;
    localparam int O_RE    = 12;
    localparam int O_WE    = 11;
    localparam int O_S2CPU = 10;
    localparam int O_CPU2S = 9;
    localparam int O_S2F   = 8;
    localparam int O_F2S   = 7;
    localparam int O_LS2C  = 6;
    localparam int O_LBYTE = 5;
    localparam int O_INCBO = 4;
    localparam int O_INCNI = 3;
    localparam int O_INCNO = 2;
    localparam int O_RIF   = 1;
    localparam int O_RDF   = 0;

    // Active-low strobes idle high.
    localparam logic [14:0] OUT_IDLE = 15'(1 << O_LS2C) | 15'(1 << O_LBYTE);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;   // 1 = SCSI to FIFO, captured at cycle start
    logic        boe_q, boe_d;   // BOEQ3 captured on entry to S_END
    logic [14:0] out_q, out_d;

    // State, counter, captured flags and registered outputs.
    always_ff @(posedge BCLK or negedge RESET_) begin
        if (!RESET_) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            boe_q   <= 1'b0;
            out_q   <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            boe_q   <= boe_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic; once a cycle starts it ignores DREQ_ and FIFO flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        boe_d   = boe_q;
        unique case (state_q)
            S_IDLE: begin
                if (CPUREQ) begin
                    state_d = RW ? S_CRD : S_CWR;
                    cnt_d   = CNT_LOAD;
                end else if (!DREQ_ && DMADIR && !FIFOFULL) begin
                    state_d = S_DRD;
                    cnt_d   = CNT_LOAD;
                    dir_d   = 1'b1;
                end else if (!DREQ_ && !DMADIR && !FIFOEMPTY) begin
                    state_d = S_DWR;
                    cnt_d   = CNT_LOAD;
                    dir_d   = 1'b0;
                end
            end
            S_CRD: begin
                if (cnt_q == 3'd0) state_d = S_CRD_LAT;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_CRD_LAT:  state_d = S_CACK;
            S_CWR: begin
                if (cnt_q == 3'd0) state_d = S_CWR_HOLD;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_CWR_HOLD: state_d = S_CACK;
            S_CACK: begin
                if (!nAS_) state_d = S_IDLE;
            end
            S_DRD: begin
                if (cnt_q == 3'd0) state_d = S_DRD_LAT;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_DRD_LAT: begin
                state_d = S_END;
                boe_d   = BOEQ3;
            end
            S_DWR: begin
                if (cnt_q == 3'd0) state_d = S_DWR_HOLD;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_DWR_HOLD: begin
                state_d = S_END;
                boe_d   = BOEQ3;
            end
            S_END: begin
                if (boe_q) state_d = dir_q ? S_HSI : S_HSO;
                else       state_d = S_IDLE;
            end
            S_HSI: begin
                if (INCFIFO) state_d = S_IDLE;
            end
            S_HSO: begin
                if (DECFIFO) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decode of the next state so the registered outputs track state_q.
    always_comb begin
        out_d = OUT_IDLE;
        unique case (state_d)
            S_CRD: begin
                out_d[O_CS] = 1'b1; out_d[O_RE] = 1'b1; out_d[O_S2CPU] = 1'b1;
            end
            S_CRD_LAT: begin
                out_d[O_CS] = 1'b1; out_d[O_RE] = 1'b1; out_d[O_S2CPU] = 1'b1;
                out_d[O_LS2C] = 1'b0;
            end
            S_CWR: begin
                out_d[O_CS] = 1'b1; out_d[O_WE] = 1'b1; out_d[O_CPU2S] = 1'b1;
            end
            S_CWR_HOLD: begin
                out_d[O_CS] = 1'b1; out_d[O_CPU2S] = 1'b1;
            end
            S_CACK: out_d[O_LS2C] = 1'b0;
            S_DRD: begin
                out_d[O_DACK] = 1'b1; out_d[O_RE] = 1'b1; out_d[O_S2F] = 1'b1;
            end
            S_DRD_LAT: begin
                out_d[O_DACK] = 1'b1; out_d[O_RE] = 1'b1; out_d[O_S2F] = 1'b1;
                out_d[O_LBYTE] = 1'b0;
            end
            S_DWR: begin
                out_d[O_DACK] = 1'b1; out_d[O_WE] = 1'b1; out_d[O_F2S] = 1'b1;
            end
            S_DWR_HOLD: begin
                out_d[O_DACK] = 1'b1; out_d[O_F2S] = 1'b1;
            end
            S_END: begin
                out_d[O_INCBO] = 1'b1;
                out_d[O_INCNI] = boe_d & dir_d;
                out_d[O_INCNO] = boe_d & ~dir_d;
            end
            S_HSI: out_d[O_RIF] = 1'b1;
            S_HSO: out_d[O_RDF] = 1'b1;
            default: out_d = OUT_IDLE;
        endcase
    end

    assign SCSI_CS_o = out_q[O_CS];
    assign DACK_o    = out_q[O_DACK];
    assign RE_o      = out_q[O_RE];
    assign WE_o      = out_q[O_WE];
    assign S2CPU_o   = out_q[O_S2CPU];
    assign CPU2S_o   = out_q[O_CPU2S];
    assign S2F_o     = out_q[O_S2F];
    assign F2S_o     = out_q[O_F2S];
    assign LS2CPU    = out_q[O_LS2C];
    assign LBYTE_    = out_q[O_LBYTE];
    assign INCBO_o   = out_q[O_INCBO];
    assign INCNI_o   = out_q[O_INCNI];
    assign INCNO_o   = out_q[O_INCNO];
    assign RIFIFO_o  = out_q[O_RIF];
    assign RDFIFO_o  = out_q[O_RDF];

endmodule

// File: tb/tb_scsi_port_sm.sv
// Directed bench for scsi_port_sm (ACC_CYCLES = 3). Inputs change and outputs
// are sampled on the falling edge of BCLK.
module tb_scsi_port_sm;

    logic BCLK, RESET_, CPUREQ, RW, nAS_, DMADIR, DREQ_, FIFOFULL, FIFOEMPTY;
    logic BOEQ3, INCFIFO, DECFIFO;
    logic SCSI_CS_o, DACK_o, RE_o, WE_o, S2CPU_o, CPU2S_o, S2F_o, F2S_o;
    logic LS2CPU, LBYTE_, INCBO_o, INCNI_o, INCNO_o, RIFIFO_o, RDFIFO_o;

    int checks   = 0;
    int failures = 0;

    scsi_port_sm #(.ACC_CYCLES(3)) dut (
        .BCLK(BCLK), .RESET_(RESET_), .CPUREQ(CPUREQ), .RW(RW), .nAS_(nAS_),
        .DMADIR(DMADIR), .DREQ_(DREQ_), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY),
        .BOEQ3(BOEQ3), .INCFIFO(INCFIFO), .DECFIFO(DECFIFO),
        .SCSI_CS_o(SCSI_CS_o), .DACK_o(DACK_o), .RE_o(RE_o), .WE_o(WE_o),
        .S2CPU_o(S2CPU_o), .CPU2S_o(CPU2S_o), .S2F_o(S2F_o), .F2S_o(F2S_o),
        .LS2CPU(LS2CPU), .LBYTE_(LBYTE_), .INCBO_o(INCBO_o), .INCNI_o(INCNI_o),
        .INCNO_o(INCNO_o), .RIFIFO_o(RIFIFO_o), .RDFIFO_o(RDFIFO_o)
    );

    initial BCLK = 1'b0;
    always #5 BCLK = ~BCLK;

    logic [14:0] obs;
    assign obs = {SCSI_CS_o, DACK_o, RE_o, WE_o, S2CPU_o, CPU2S_o, S2F_o, F2S_o,
                  LS2CPU, LBYTE_, INCBO_o, INCNI_o, INCNO_o, RIFIFO_o, RDFIFO_o};

    localparam logic [14:0] CS = 15'h4000, DK = 15'h2000, RE = 15'h1000, WE = 15'h0800;
    localparam logic [14:0] SC = 15'h0400, CS2 = 15'h0200, SF = 15'h0100, FS = 15'h0080;
    localparam logic [14:0] LS = 15'h0040, LB = 15'h0020, BO = 15'h0010, NI = 15'h0008;
    localparam logic [14:0] NO = 15'h0004, RI = 15'h0002, RD = 15'h0001;

    localparam logic [14:0] E_IDLE = LS | LB;
    localparam logic [14:0] E_CRD  = CS | RE | SC | LS | LB;
    localparam logic [14:0] E_CRDL = CS | RE | SC | LB;
    localparam logic [14:0] E_CWR  = CS | WE | CS2 | LS | LB;
    localparam logic [14:0] E_CWRH = CS | CS2 | LS | LB;
    localparam logic [14:0] E_CACK = LB;
    localparam logic [14:0] E_DRD  = DK | RE | SF | LS | LB;
    localparam logic [14:0] E_DRDL = DK | RE | SF | LS;
    localparam logic [14:0] E_DWR  = DK | WE | FS | LS | LB;
    localparam logic [14:0] E_DWRH = DK | FS | LS | LB;
    localparam logic [14:0] E_END  = BO | LS | LB;
    localparam logic [14:0] E_ENDI = BO | NI | LS | LB;
    localparam logic [14:0] E_ENDO = BO | NO | LS | LB;
    localparam logic [14:0] E_HSI  = RI | LS | LB;
    localparam logic [14:0] E_HSO  = RD | LS | LB;

    task automatic test_reset;
        RESET_ = 1'b0;
        @(negedge BCLK);
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs, E_IDLE);
        end
        RESET_ = 1'b1;
        @(negedge BCLK);
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs, E_IDLE);
        end
    endtask

    task automatic test_reset_mid_drd;
        DMADIR = 1'b1; FIFOFULL = 1'b0; DREQ_ = 1'b0;
        @(negedge BCLK);
        checks++;
        if (obs !== E_DRD) begin
            failures++;
            $display("FAIL rst_drd_start got=%h exp=%h", obs, E_DRD);
        end
        @(negedge BCLK);
        #2 RESET_ = 1'b0;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL rst_async got=%h exp=%h", obs, E_IDLE);
        end
        DREQ_ = 1'b1;
        @(negedge BCLK);
        RESET_ = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge BCLK);
            checks++;
            if (obs !== E_IDLE) begin
                failures++;
                $display("FAIL rst_after cyc=%0d got=%h exp=%h", i, obs, E_IDLE);
            end
        end
    endtask

    task automatic test_cpu_read;
        logic [14:0] exp[$];
        exp = '{E_CRD, E_CRD, E_CRD, E_CRDL, E_CACK, E_CACK, E_CACK, E_IDLE, E_IDLE};
        CPUREQ = 1'b1; RW = 1'b1; nAS_ = 1'b1;
        foreach (exp[i]) begin
            @(negedge BCLK);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL cpu_read cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
            if (i == 0) CPUREQ = 1'b0;
            if (i == 6) nAS_ = 1'b0;
        end
    endtask

    task automatic test_cpu_write;
        logic [14:0] exp[$];
        exp = '{E_CWR, E_CWR, E_CWR, E_CWRH, E_CACK, E_CACK, E_IDLE};
        CPUREQ = 1'b1; RW = 1'b0; nAS_ = 1'b1;
        foreach (exp[i]) begin
            @(negedge BCLK);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL cpu_write cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
            if (i == 0) begin CPUREQ = 1'b0; RW = 1'b1; end
            if (i == 5) nAS_ = 1'b0;
        end
    endtask

    task automatic test_dma_read;
        int n_lbyte = 0, n_incbo = 0, n_incni = 0;
        logic [14:0] exp[$];
        DMADIR = 1'b1; FIFOFULL = 1'b0; DREQ_ = 1'b0; INCFIFO = 1'b0;
        for (int b = 0; b < 4; b++) begin
            BOEQ3 = (b == 3);
            exp = '{E_DRD, E_DRD, E_DRD, E_DRDL, (b == 3) ? E_ENDI : E_END,
                    (b == 3) ? E_HSI : E_IDLE};
            foreach (exp[i]) begin
                @(negedge BCLK);
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL dma_read byte=%0d cyc=%0d got=%h exp=%h", b, i, obs, exp[i]);
                end
                if (!LBYTE_)  n_lbyte++;
                if (INCBO_o)  n_incbo++;
                if (INCNI_o)  n_incni++;
            end
        end
        BOEQ3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge BCLK);
            checks++;
            if (obs !== E_HSI) begin
                failures++;
                $display("FAIL dma_read_hsi_hold cyc=%0d got=%h exp=%h", i, obs, E_HSI);
            end
        end
        INCFIFO = 1'b1; DREQ_ = 1'b1;
        @(negedge BCLK);
        INCFIFO = 1'b0;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL dma_read_hsi_exit got=%h exp=%h", obs, E_IDLE);
        end
        checks++;
        if (n_lbyte != 4) begin
            failures++;
            $display("FAIL dma_read_lbyte_count got=%0d exp=4", n_lbyte);
        end
        checks++;
        if (n_incbo != 4) begin
            failures++;
            $display("FAIL dma_read_incbo_count got=%0d exp=4", n_incbo);
        end
        checks++;
        if (n_incni != 1) begin
            failures++;
            $display("FAIL dma_read_incni_count got=%0d exp=1", n_incni);
        end
    endtask

    task automatic test_dma_write;
        int n_incno = 0;
        logic [14:0] exp[$];
        DMADIR = 1'b0; FIFOEMPTY = 1'b1; DREQ_ = 1'b0; DECFIFO = 1'b0; BOEQ3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge BCLK);
            checks++;
            if (obs !== E_IDLE) begin
                failures++;
                $display("FAIL dma_write_empty cyc=%0d got=%h exp=%h", i, obs, E_IDLE);
            end
        end
        FIFOEMPTY = 1'b0;
        for (int b = 0; b < 4; b++) begin
            BOEQ3 = (b == 3);
            exp = '{E_DWR, E_DWR, E_DWR, E_DWRH, (b == 3) ? E_ENDO : E_END,
                    (b == 3) ? E_HSO : E_IDLE};
            foreach (exp[i]) begin
                @(negedge BCLK);
                checks++;
                if (obs !== exp[i]) begin
                    failures++;
                    $display("FAIL dma_write byte=%0d cyc=%0d got=%h exp=%h", b, i, obs, exp[i]);
                end
                if (INCNO_o) n_incno++;
                // Request and FIFO flag drop mid-byte must not abort it.
                if (b == 3 && i == 0) begin DREQ_ = 1'b1; FIFOEMPTY = 1'b1; end
            end
        end
        BOEQ3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge BCLK);
            checks++;
            if (obs !== E_HSO) begin
                failures++;
                $display("FAIL dma_write_hso_hold cyc=%0d got=%h exp=%h", i, obs, E_HSO);
            end
        end
        DECFIFO = 1'b1;
        @(negedge BCLK);
        DECFIFO = 1'b0;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL dma_write_hso_exit got=%h exp=%h", obs, E_IDLE);
        end
        checks++;
        if (n_incno != 1) begin
            failures++;
            $display("FAIL dma_write_incno_count got=%0d exp=1", n_incno);
        end
    endtask

    task automatic test_back_to_back;
        logic [14:0] exp[$];
        exp = '{E_CRD, E_CRD, E_CRD, E_CRDL, E_CACK, E_CACK, E_IDLE,
                E_DRD, E_DRD, E_DRD, E_DRDL, E_END, E_IDLE, E_IDLE};
        CPUREQ = 1'b1; RW = 1'b1; nAS_ = 1'b1;
        DMADIR = 1'b1; FIFOFULL = 1'b0; DREQ_ = 1'b0; BOEQ3 = 1'b0;
        foreach (exp[i]) begin
            @(negedge BCLK);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs, exp[i]);
            end
            checks++;
            if ((SCSI_CS_o & DACK_o) !== 1'b0) begin
                failures++;
                $display("FAIL cs_dack_overlap cyc=%0d got=%b exp=0", i, SCSI_CS_o & DACK_o);
            end
            if (i == 0)  CPUREQ = 1'b0;
            if (i == 5)  nAS_ = 1'b0;
            if (i == 11) DREQ_ = 1'b1;
        end
    endtask

    initial begin
        RESET_ = 1'b0; CPUREQ = 1'b0; RW = 1'b0; nAS_ = 1'b0; DMADIR = 1'b0;
        DREQ_ = 1'b1; FIFOFULL = 1'b0; FIFOEMPTY = 1'b1; BOEQ3 = 1'b0;
        INCFIFO = 1'b0; DECFIFO = 1'b0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_dma_read();
        test_dma_write();
        test_back_to_back();
        test_reset_mid_drd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
